// File: rtl/rotate_sequencer.sv
// rotate_sequencer: multi-cycle 0-31 bit rotate of a 32-bit word.
// One rotate_step instance is reused every RUN cycle. Each cycle it moves
// the word by 2 bits when possible, and by a single bit at the end when
// the amount is odd. A start/busy/done handshake faces the control unit.

// Single-step rotate unit. sel: 0 = left 1, 1 = left 2, 2 = right 1, 3 = right 2.
// The carry is the bit that lands in r[0] (left) or in r[31] (right).
module rotate_step (
    input  logic [31:0] x,
    input  logic [1:0]  sel,
    output logic [31:0] r,
    output logic        c
);

    // Pure combinational rotate selected by sel.
    always_comb begin
        // NOTE: assign every output first so no path through the case can infer a latch.
        r = x;
        c = 1'b0;
        case (sel)
            2'd0: begin r = {x[30:0], x[31]};    c = x[31]; end
            2'd1: begin r = {x[29:0], x[31:30]}; c = x[30]; end
            2'd2: begin r = {x[0], x[31:1]};     c = x[0];  end
            2'd3: begin r = {x[1:0], x[31:2]};   c = x[1];  end
            default: begin r = x; c = 1'b0; end
        endcase
    end

endmodule

module rotate_sequencer #(
    parameter bit ALLOW_STEP2 = 1'b1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [4:0]  amount,
    input  logic        dir,
    output logic [31:0] y,
    output logic        c_out,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] y_q, y_d;
    logic        c_q, c_d;
    logic [4:0]  rem_q, rem_d;
    logic        drg_q, drg_d;

    logic        step2;
    logic [4:0]  step_amt;
    logic [4:0]  rem_next;
    logic [1:0]  sel;
    logic [31:0] step_y;
    logic        step_c;

    // A 2-step is issued only while at least 2 bits remain, so rem never underflows.
    assign step2    = ALLOW_STEP2 && (rem_q >= 5'd2);
    assign step_amt = step2 ? 5'd2 : 5'd1;
    assign rem_next = rem_q - step_amt;
    assign sel      = {drg_q, step2};

    rotate_step u_step (
        .x   (y_q),
        .sel (sel),
        .r   (step_y),
        .c   (step_c)
    );

    // Next-state and datapath update for the IDLE -> RUN -> DONE sequence.
    always_comb begin
        state_d = state_q;
        y_d     = y_q;
        c_d     = c_q;
        rem_d   = rem_q;
        drg_d   = drg_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    y_d     = a;
                    rem_d   = amount;
                    drg_d   = dir;
                    c_d     = 1'b0;
                    state_d = (amount == 5'd0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                y_d   = step_y;
                c_d   = step_c;
                rem_d = rem_next;
                if (rem_next == 5'd0) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: reset is sampled on the clock edge only, so it must sit inside the clocked block as the first branch.
        if (!reset_n) begin
            state_q <= S_IDLE;
            y_q     <= 32'd0;
            c_q     <= 1'b0;
            rem_q   <= 5'd0;
            drg_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the pre-edge values.
            state_q <= state_d;
            y_q     <= y_d;
            c_q     <= c_d;
            rem_q   <= rem_d;
            drg_q   <= drg_d;
        end
    end

    assign y     = y_q;
    assign c_out = c_q;
    assign busy  = (state_q != S_IDLE);
    assign done  = (state_q == S_DONE);

endmodule

// File: tb/tb_rotate_sequencer.sv
// Directed testbench for rotate_sequencer. Two instances share the stimulus:
// u_dut2 with 2-bit steps enabled, and u_dut1 restricted to single-bit steps.
module tb_rotate_sequencer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [31:0] a;
    logic [4:0]  amount;
    logic        dir;

    logic [31:0] y2, y1;
    logic        c2, c1, busy2, busy1, done2, done1;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    rotate_sequencer #(.ALLOW_STEP2(1'b1)) u_dut2 (
        .clk(clk), .reset_n(reset_n), .start(start), .a(a), .amount(amount), .dir(dir),
        .y(y2), .c_out(c2), .busy(busy2), .done(done2)
    );

    rotate_sequencer #(.ALLOW_STEP2(1'b0)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .start(start), .a(a), .amount(amount), .dir(dir),
        .y(y1), .c_out(c1), .busy(busy1), .done(done1)
    );

    typedef struct {
        logic [31:0] y;
        logic        c;
        int          lat;
        int          pulses;
        int          busy_err;
        logic [31:0] y_end;
        logic        c_end;
    } obs_t;

    typedef struct {
        logic [31:0] a;
        logic [4:0]  amt;
        logic        dir;
        logic [31:0] y_exp;
        logic        c_exp;
        int          s_exp2;
        int          s_exp1;
    } vec_t;

    // Issue one request, then watch both instances for 40 cycles.
    // lat is the cycle index of the first done, counted from the first
    // cycle after the accepting edge (0 = that cycle).
    task automatic run_op(input logic [31:0] a_i, input logic [4:0] amt_i, input logic dir_i,
                          output obs_t o2, output obs_t o1);
        logic [39:0] b2, b1;
        o2.y = '0; o2.c = 1'b0; o2.lat = -1; o2.pulses = 0; o2.busy_err = 0;
        o1.y = '0; o1.c = 1'b0; o1.lat = -1; o1.pulses = 0; o1.busy_err = 0;
        @(negedge clk);
        start = 1'b1; a = a_i; amount = amt_i; dir = dir_i;
        @(negedge clk);
        start = 1'b0; a = ~a_i; amount = ~amt_i; dir = ~dir_i;
        for (int j = 0; j < 40; j++) begin
            b2[j] = busy2;
            b1[j] = busy1;
            if (done2) begin
                if (o2.pulses == 0) begin o2.lat = j; o2.y = y2; o2.c = c2; end
                o2.pulses++;
            end
            if (done1) begin
                if (o1.pulses == 0) begin o1.lat = j; o1.y = y1; o1.c = c1; end
                o1.pulses++;
            end
            if (j != 39) @(negedge clk);
        end
        o2.y_end = y2; o2.c_end = c2;
        o1.y_end = y1; o1.c_end = c1;
        for (int j = 0; j < 40; j++) begin
            if (b2[j] !== ((o2.lat < 0) || (j <= o2.lat))) o2.busy_err++;
            if (b1[j] !== ((o1.lat < 0) || (j <= o1.lat))) o1.busy_err++;
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; start = 1'b0; a = 32'hFFFF_FFFF; amount = 5'd7; dir = 1'b1;
        repeat (2) @(negedge clk);
        total++; if (y2 !== 32'd0 || y1 !== 32'd0) begin bad++;
            $display("FAIL reset_y: got %h/%h want 00000000", y2, y1); end
        total++; if (c2 !== 1'b0 || c1 !== 1'b0) begin bad++;
            $display("FAIL reset_c: got %b/%b want 0", c2, c1); end
        total++; if (busy2 !== 1'b0 || busy1 !== 1'b0) begin bad++;
            $display("FAIL reset_busy: got %b/%b want 0", busy2, busy1); end
        total++; if (done2 !== 1'b0 || done1 !== 1'b0) begin bad++;
            $display("FAIL reset_done: got %b/%b want 0", done2, done1); end
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_rotate_vectors();
        vec_t v[6];
        obs_t ob[2];
        obs_t o2, o1;
        int   s_exp;
        v[0] = '{32'h8000_0001, 5'd1,  1'b0, 32'h0000_0003, 1'b1, 1,  1};
        v[1] = '{32'h1234_5678, 5'd4,  1'b0, 32'h2345_6781, 1'b1, 2,  4};
        v[2] = '{32'h0000_000F, 5'd3,  1'b1, 32'hE000_0001, 1'b1, 2,  3};
        v[3] = '{32'hDEAD_BEEF, 5'd0,  1'b0, 32'hDEAD_BEEF, 1'b0, 0,  0};
        v[4] = '{32'h0000_0001, 5'd31, 1'b0, 32'h8000_0000, 1'b0, 16, 31};
        v[5] = '{32'h0000_0003, 5'd2,  1'b1, 32'hC000_0000, 1'b1, 1,  2};
        for (int i = 0; i < 6; i++) begin
            run_op(v[i].a, v[i].amt, v[i].dir, o2, o1);
            ob[0] = o2;
            ob[1] = o1;
            for (int k = 0; k < 2; k++) begin
                s_exp = (k == 0) ? v[i].s_exp2 : v[i].s_exp1;
                total++; if (ob[k].y !== v[i].y_exp) begin bad++;
                    $display("FAIL vec%0d_y inst%0d: got %h want %h", i, k, ob[k].y, v[i].y_exp); end
                total++; if (ob[k].c !== v[i].c_exp) begin bad++;
                    $display("FAIL vec%0d_c inst%0d: got %b want %b", i, k, ob[k].c, v[i].c_exp); end
                total++; if (ob[k].lat != s_exp) begin bad++;
                    $display("FAIL vec%0d_latency inst%0d: got %0d want %0d", i, k, ob[k].lat, s_exp); end
                total++; if (ob[k].pulses != 1) begin bad++;
                    $display("FAIL vec%0d_pulses inst%0d: got %0d want 1", i, k, ob[k].pulses); end
                total++; if (ob[k].busy_err != 0) begin bad++;
                    $display("FAIL vec%0d_busy inst%0d: %0d wrong cycles want 0", i, k, ob[k].busy_err); end
                total++; if (ob[k].y_end !== v[i].y_exp || ob[k].c_end !== v[i].c_exp) begin bad++;
                    $display("FAIL vec%0d_hold inst%0d: got %h/%b want %h/%b", i, k,
                             ob[k].y_end, ob[k].c_end, v[i].y_exp, v[i].c_exp); end
            end
        end
    endtask

    // start held high through back-to-back amount=10 operations.
    // Step-2 instance: period 7 (S=5), done at 5,12,19,26, idle at 6,13,20,27.
    // Step-1 instance: period 12 (S=10), done at 10,22, idle at 11,23.
    task automatic test_start_while_busy();
        int p2 = 0, p1 = 0, lo2 = 0, lo1 = 0, f2 = -1, f1 = -1;
        logic [31:0] fy2 = '0, fy1 = '0;
        @(negedge clk);
        start = 1'b1; a = 32'h1234_5678; amount = 5'd10; dir = 1'b0;
        @(negedge clk);
        for (int j = 0; j < 30; j++) begin
            if (done2) begin if (f2 < 0) begin f2 = j; fy2 = y2; end p2++; end
            if (done1) begin if (f1 < 0) begin f1 = j; fy1 = y1; end p1++; end
            if (!busy2) lo2++;
            if (!busy1) lo1++;
            @(negedge clk);
        end
        start = 1'b0;
        total++; if (p2 != 4 || p1 != 2) begin bad++;
            $display("FAIL bb_pulses: got %0d/%0d want 4/2", p2, p1); end
        total++; if (lo2 != 4 || lo1 != 2) begin bad++;
            $display("FAIL bb_idle_cycles: got %0d/%0d want 4/2", lo2, lo1); end
        total++; if (f2 != 5 || f1 != 10) begin bad++;
            $display("FAIL bb_first_done: got %0d/%0d want 5/10", f2, f1); end
        total++; if (fy2 !== 32'hD159_E048 || fy1 !== 32'hD159_E048) begin bad++;
            $display("FAIL bb_y: got %h/%h want d159e048", fy2, fy1); end
        repeat (15) @(negedge clk);
    endtask

    task automatic test_reset_mid_op();
        int   p = 0, bz = 0;
        obs_t o2, o1;
        @(negedge clk);
        start = 1'b1; a = 32'hA5A5_A5A5; amount = 5'd20; dir = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (busy2 !== 1'b1 || busy1 !== 1'b1) begin bad++;
            $display("FAIL abort_pre_busy: got %b/%b want 1", busy2, busy1); end
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        total++; if (y2 !== 32'd0 || y1 !== 32'd0 || c2 !== 1'b0 || c1 !== 1'b0) begin bad++;
            $display("FAIL abort_yc: got %h %b / %h %b want 0", y2, c2, y1, c1); end
        total++; if (busy2 !== 1'b0 || busy1 !== 1'b0 || done2 !== 1'b0 || done1 !== 1'b0) begin bad++;
            $display("FAIL abort_flags: busy %b/%b done %b/%b want 0", busy2, busy1, done2, done1); end
        for (int j = 0; j < 25; j++) begin
            @(negedge clk);
            if (done2 || done1) p++;
            if (busy2 || busy1) bz++;
        end
        total++; if (p != 0 || bz != 0) begin bad++;
            $display("FAIL abort_quiet: done %0d busy %0d cycles want 0", p, bz); end
        run_op(32'hA5A5_A5A5, 5'd20, 1'b0, o2, o1);
        total++; if (o2.y !== 32'h5A5A_5A5A || o1.y !== 32'h5A5A_5A5A) begin bad++;
            $display("FAIL after_abort_y: got %h/%h want 5a5a5a5a", o2.y, o1.y); end
        total++; if (o2.c !== 1'b0 || o1.c !== 1'b0) begin bad++;
            $display("FAIL after_abort_c: got %b/%b want 0", o2.c, o1.c); end
        total++; if (o2.lat != 10 || o1.lat != 20) begin bad++;
            $display("FAIL after_abort_latency: got %0d/%0d want 10/20", o2.lat, o1.lat); end
        total++; if (o2.pulses != 1 || o1.pulses != 1) begin bad++;
            $display("FAIL after_abort_pulses: got %0d/%0d want 1/1", o2.pulses, o1.pulses); end
    endtask

    initial begin
        test_reset();
        test_rotate_vectors();
        test_start_while_busy();
        test_reset_mid_op();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rotate_sequencer.md
Name: rotate_sequencer

Overview:
- Multi-cycle controller that performs an arbitrary 0-31 bit rotate of a 32-bit word.
- Drives one instance of the team's single-step rotate unit. Its 2-bit select encodes: 0 = left 1, 1 = left 2, 2 = right 1, 3 = right 2.
- Iterates steps of 2 (and a final step of 1 when needed) until the requested amount is consumed.
- Sits beside the ALU as the execution engine for variable-amount rotate instructions, using a start/busy/done handshake toward the control unit.

Parameters:
- ALLOW_STEP2, 1: when 1, steps of 2 are used where possible. When 0, only single-bit steps are issued (select 0/2 only).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset_n  input  1  synchronous, active-low reset.
- start  input  1  request; sampled only in IDLE.
- a  input  32  operand, captured when start is accepted.
- amount  input  5  rotate distance 0-31, captured with a.
- dir  input  1  0 = rotate left, 1 = rotate right; captured with a.
- y  output  32  result register.
- c_out  output  1  carry of the last step issued.
- busy  output  1  high from the cycle after acceptance through the done cycle.
- done  output  1  one-cycle pulse; y/c_out valid.

Behaviour:
- Reset (reset_n = 0 at a clock edge) has priority over everything. It forces state = IDLE, y = 0, c_out = 0, busy = 0, done = 0, and clears the remaining-count and direction registers.
- A reset mid-operation aborts the operation with no done pulse.
- Clock and reset port names: clk and reset_n. Reset is synchronous and active-low.
- States:
  - IDLE: busy = 0, done = 0. On start = 1: capture a into the working register y, amount into rem, dir into drg, and clear c_out. Go to DONE if amount = 0, else go to RUN.
  - RUN: busy = 1. Each cycle: step = 2 if (ALLOW_STEP2 and rem >= 2), else 1. The select is {drg, step == 2}. Update y <= rotate unit output, c_out <= rotate unit carry, rem <= rem - step. If rem - step = 0, go to DONE, else stay in RUN.
  - DONE: busy = 1, done = 1 for exactly one cycle. y and c_out are held. Next state is IDLE unconditionally.
- Step count: S = ceil(N/2) when ALLOW_STEP2 = 1, S = N when ALLOW_STEP2 = 0.
- Timing: if start is sampled at edge k, done is high in the cycle following edge k+S. For N = 0 that is the cycle immediately after edge k.
- Carry semantics:
  - c_out is the bit moved by the final step into y[0] (left) or into y[31] (right).
  - So after completion c_out = y[0] for left and c_out = y[31] for right.
  - For N = 0, c_out = 0.
- y and c_out hold their final values in IDLE until the next accepted start.
- start during RUN or DONE is ignored. No queuing; the requester must re-assert start in IDLE.
- a, amount and dir may change freely after acceptance.
- rem is 5 bits. It never underflows, because a 2-step is only issued when rem >= 2.

Test Plan:
- Left rotate by 1: a=0x80000001, amount=1, dir=0 -> done one cycle after acceptance (S=1), y=0x00000003, c_out=1.
- Left rotate by 4: a=0x12345678, amount=4, dir=0 -> two RUN cycles, y=0x23456781, c_out=1.
- Odd right rotate: a=0x0000000F, amount=3, dir=1 -> selects 3 then 2, y=0xE0000001, c_out=1. With ALLOW_STEP2=0 the result is the same but takes 3 steps.
- Zero and maximum amount:
  - amount=0, a=0xDEADBEEF -> done in the first cycle after acceptance, y=0xDEADBEEF, c_out=0.
  - amount=31, dir=0, a=0x00000001 -> 16 steps, y=0x80000000, c_out=0.
- Start while busy: start held high throughout an amount=10 operation -> exactly one done pulse per accepted request. The second operation begins only after the cycle in IDLE, and busy never drops mid-operation.
- Reset mid-operation: reset_n=0 during RUN of amount=20 -> next cycle y=0, c_out=0, busy=0, no done pulse. A fresh start afterward completes correctly.
